// File: rtl/button_conditioner_pkg.sv
// Shared types and constants for the push-button conditioning stage.
//   BtnState : per-channel debounce FSM state encoding
//   BTN_*    : channel index constants for the board buttons
//   BtnVec   : one bit per button channel
package button_conditioner_pkg;

  localparam int NUM_BTN = 3;

  localparam int BTN_CENTER = 0;
  localparam int BTN_UP     = 1;
  localparam int BTN_DOWN   = 2;

  typedef logic [NUM_BTN-1:0] BtnVec;

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    WAIT_HI   = 2'd1,
    STABLE_HI = 2'd2,
    WAIT_LO   = 2'd3
  } BtnState;

endpackage

// File: rtl/debounce_channel.sv
// One button channel: input synchronizer, debounce FSM and stability counter.
// Ports:
//   clk      fast clock, rising edge
//   rst      synchronous reset, active low
//   raw      raw asynchronous button level (1 = pressed)
//   level    debounced level (registered)
//   press    one-cycle pulse on an accepted 0->1 change (registered)
//   released one-cycle pulse on an accepted 1->0 change (registered)
//   active   high while the FSM is in a WAIT state (from the state register)
module debounce_channel
  import button_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 200000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press,
  output logic released,
  output logic active
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   s;

  BtnState         state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic            level_reg, level_next;
  logic            press_reg, press_next;
  logic            rel_reg, rel_next;

  // raw enters at bit 0 and leaves at the top bit
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], raw};
    end
  end

  assign s = sync_reg[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= STABLE_LO;
      cnt_reg   <= '0;
      level_reg <= 1'b0;
      press_reg <= 1'b0;
      rel_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      level_reg <= level_next;
      press_reg <= press_next;
      rel_reg   <= rel_next;
    end
  end

  // Entering a WAIT state already counts the first stable sample, so the
  // change is accepted once the count reaches DEBOUNCE_CYCLES-1. The compare
  // happens before the increment, so the counter never wraps; >= keeps the
  // DEBOUNCE_CYCLES=1 case accepting on the edge after entry.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    level_next = level_reg;
    press_next = 1'b0;
    rel_next   = 1'b0;
    case (state_reg)
      STABLE_LO: begin
        if (s) begin
          state_next = WAIT_HI;
          cnt_next   = CNT_ONE;
        end
      end
      WAIT_HI: begin
        if (!s) begin
          state_next = STABLE_LO;
          cnt_next   = '0;
        end else if (cnt_reg >= CNT_LAST) begin
          state_next = STABLE_HI;
          cnt_next   = '0;
          level_next = 1'b1;
          press_next = 1'b1;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      STABLE_HI: begin
        if (!s) begin
          state_next = WAIT_LO;
          cnt_next   = CNT_ONE;
        end
      end
      WAIT_LO: begin
        if (s) begin
          state_next = STABLE_HI;
          cnt_next   = '0;
        end else if (cnt_reg >= CNT_LAST) begin
          state_next = STABLE_LO;
          cnt_next   = '0;
          level_next = 1'b0;
          rel_next   = 1'b1;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      default: begin
        state_next = STABLE_LO;
        cnt_next   = '0;
      end
    endcase
  end

  assign level    = level_reg;
  assign press    = press_reg;
  assign released = rel_reg;
  assign active   = (state_reg == WAIT_HI) || (state_reg == WAIT_LO);

endmodule

// File: rtl/button_conditioner.sv
// Push-button conditioner: synchronizes and debounces NUM_BTN raw buttons.
// Ports:
//   clk         fast clock (clkX4 domain), rising edge
//   rst         synchronous reset, active low
//   btnRaw      raw asynchronous button levels, 1 = pressed
//   btnLevel    debounced levels
//   btnPress    one-cycle pulse per accepted 0->1 change
//   btnRelease  one-cycle pulse per accepted 1->0 change
//   anyActive   OR of all channels currently debouncing
module button_conditioner #(
  parameter int NUM_BTN         = 3,
  parameter int DEBOUNCE_CYCLES = 200000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btnRaw,
  output logic [NUM_BTN-1:0] btnLevel,
  output logic [NUM_BTN-1:0] btnPress,
  output logic [NUM_BTN-1:0] btnRelease,
  output logic               anyActive
);

  logic [NUM_BTN-1:0] active_vec;

  generate
    for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_chan
      debounce_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .SYNC_STAGES     (SYNC_STAGES)
      ) u_chan (
        .clk      (clk),
        .rst      (rst),
        .raw      (btnRaw[gi]),
        .level    (btnLevel[gi]),
        .press    (btnPress[gi]),
        .released (btnRelease[gi]),
        .active   (active_vec[gi])
      );
    end
  endgenerate

  assign anyActive = |active_vec;

endmodule

// File: tb/tb_button_conditioner.sv
module tb_button_conditioner;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] btnRaw;
  logic [2:0] btnLevel;
  logic [2:0] btnPress;
  logic [2:0] btnRelease;
  logic       anyActive;

  button_conditioner #(
    .NUM_BTN         (3),
    .DEBOUNCE_CYCLES (4),
    .SYNC_STAGES     (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btnRaw     (btnRaw),
    .btnLevel   (btnLevel),
    .btnPress   (btnPress),
    .btnRelease (btnRelease),
    .anyActive  (anyActive)
  );

  always #5 clk = ~clk;

  // cyc = number of rising edges seen so far; stable at every falling edge.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [2:0] press;
    logic [2:0] rel;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Input driven at the falling edge of cycle c is first sampled at edge c+1;
  // with 2 sync stages and 4 debounce cycles the pulse comes at edge c+6.
  task automatic push(input int c, input logic [2:0] p, input logic [2:0] r);
    exp_t e;
    e.cyc   = c + 6;
    e.press = p;
    e.rel   = r;
    sb.push_back(e);
    $display("[TB] expect at cycle %0d press=%b release=%b", e.cyc, p, r);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Scoreboard consumer: every pulse cycle must match the oldest expectation.
  always @(negedge clk) begin
    if ((|btnPress) === 1'b1 || (|btnRelease) === 1'b1) begin
      $display("[TB] cycle %0d press=%b release=%b level=%b", cyc, btnPress, btnRelease, btnLevel);
      if (sb.size() == 0) begin
        chk("unexpected_pulse", 32'({btnPress, btnRelease}), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("pulse_cycle", 32'(cyc), 32'(mon_e.cyc));
        chk("press_vec", 32'(btnPress), 32'(mon_e.press));
        chk("release_vec", 32'(btnRelease), 32'(mon_e.rel));
      end
      chk("press_release_exclusive", 32'(btnPress & btnRelease), 32'd0);
    end
  end

  initial begin
    int hi_cnt;
    logic seen_active;
    logic [4:0] bounce;

    // Reset held with all buttons pressed
    rst    = 1'b0;
    btnRaw = 3'b111;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("reset_outputs", 32'({btnLevel, btnPress, btnRelease, anyActive}), 32'd0);
    end
    rst = 1'b1;
    push(cyc, 3'b111, 3'b000);
    repeat (10) tick();
    chk("level_after_reset_press", 32'(btnLevel), 32'b111);

    // Release everything to get back to a known low state
    btnRaw = 3'b000;
    push(cyc, 3'b000, 3'b111);
    repeat (10) tick();
    chk("level_all_low", 32'(btnLevel), 32'b000);
    chk("idle_not_active", 32'(anyActive), 32'd0);

    // Clean press/release on channel 0, held 10 cycles
    hi_cnt = 0;
    btnRaw[0] = 1'b1;
    push(cyc, 3'b001, 3'b000);
    for (int i = 0; i < 10; i++) begin
      tick();
      if (btnLevel[0] === 1'b1) hi_cnt++;
    end
    btnRaw[0] = 1'b0;
    push(cyc, 3'b000, 3'b001);
    for (int i = 0; i < 12; i++) begin
      tick();
      if (btnLevel[0] === 1'b1) hi_cnt++;
    end
    chk("ch0_level_high_cycles", 32'(hi_cnt), 32'd10);
    chk("ch0_level_low", 32'(btnLevel), 32'b000);

    // Bounce reject on channel 1: 1,0,1,1,0 then hold 0
    seen_active = 1'b0;
    bounce = 5'b01101;
    for (int i = 0; i < 5; i++) begin
      btnRaw[1] = bounce[i];
      tick();
      if (anyActive === 1'b1) seen_active = 1'b1;
    end
    btnRaw[1] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (anyActive === 1'b1) seen_active = 1'b1;
    end
    chk("bounce_active_seen", 32'(seen_active), 32'd1);
    chk("bounce_active_cleared", 32'(anyActive), 32'd0);
    chk("bounce_level_low", 32'(btnLevel), 32'b000);

    // Bounce then settle on channel 1: 1,0 then hold 1
    btnRaw[1] = 1'b1;
    tick();
    btnRaw[1] = 1'b0;
    tick();
    btnRaw[1] = 1'b1;
    push(cyc, 3'b010, 3'b000);
    repeat (10) tick();
    chk("settle_level", 32'(btnLevel), 32'b010);

    // Reset two edges into WAIT_HI on channel 2
    btnRaw[2] = 1'b1;
    repeat (4) tick();
    chk("ch2_waiting_before_reset", 32'(anyActive), 32'd1);
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("mid_reset_outputs", 32'({btnLevel, btnPress, btnRelease, anyActive}), 32'd0);
    end
    rst = 1'b1;
    // channel 1 is still held, so it re-presses alongside channel 2
    push(cyc, 3'b110, 3'b000);
    repeat (10) tick();
    chk("after_mid_reset_level", 32'(btnLevel), 32'b110);

    // Simultaneous: channel 0 rises, channel 2 falls, channel 1 held
    btnRaw = 3'b011;
    push(cyc, 3'b001, 3'b100);
    repeat (10) tick();
    chk("simultaneous_level", 32'(btnLevel), 32'b011);
    chk("simultaneous_idle", 32'(anyActive), 32'd0);

    repeat (4) tick();
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Input-conditioning stage directly upstream of the CPU top. Takes raw, asynchronous push-button levels (centre/up/down) and turns them into debounced levels and single-cycle press/release pulses.
- The CPU control logic consumes these outputs for run/step/reset-request decisions.
- One instance per board. Runs in the fast (clkX4) clock domain.

Parameters:
- NUM_BTN, 3, number of independent button channels.
- DEBOUNCE_CYCLES, 200000, consecutive stable clock cycles required before a level change is accepted. Legal range 1..2^24-1.
- SYNC_STAGES, 2, flip-flop depth of the input synchronizer. Legal range 2..4.

Ports:
- clk  input  1  fast clock (clkX4 domain), rising-edge.
- rst  input  1  reset, synchronous, active-low.
- btnRaw  input  NUM_BTN  raw asynchronous button levels, 1 = pressed.
- btnLevel  output  NUM_BTN  debounced button level.
- btnPress  output  NUM_BTN  one-cycle pulse on an accepted 0->1 transition.
- btnRelease  output  NUM_BTN  one-cycle pulse on an accepted 1->0 transition.
- anyActive  output  1  OR of all channels currently in a WAIT state (debounce in progress).

Behaviour:
- Reset: rst sampled low at a rising edge clears the following:
  - all synchronizer flops
  - all counters
  - every channel to state STABLE_LO
  - btnLevel, btnPress, btnRelease and anyActive, all to 0
- Reset asserted mid-debounce discards the partial count. No pulse is emitted.
- Synchronizer: SYNC_STAGES flops per channel. The synchronized value s is the last stage. No other logic reads btnRaw.
- Per-channel FSM has four states: STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO.
  - STABLE_LO: if s=1, go to WAIT_HI with cnt=1. Otherwise stay.
  - WAIT_HI:
    - if s=0, return to STABLE_LO with cnt=0 and no pulse;
    - else if cnt==DEBOUNCE_CYCLES-1, go to STABLE_HI, set btnLevel=1, assert btnPress for exactly one cycle;
    - else cnt+1.
  - STABLE_HI and WAIT_LO mirror the above with btnRelease.
  - DEBOUNCE_CYCLES=1: WAIT_HI/WAIT_LO are entered and then accepted on the very next edge unless s reverted (bounce of one sample is rejected).
- Latency: a clean step on btnRaw, first sampled at edge e0, raises btnLevel and btnPress at edge e0+SYNC_STAGES-1+DEBOUNCE_CYCLES.
  - With SYNC_STAGES=2 and DEBOUNCE_CYCLES=4, that is 5 edges after e0.
- btnPress and btnRelease are registered outputs. They are never both high on one channel. Each is high for exactly one cycle per accepted transition.
- Counter: width is $clog2(DEBOUNCE_CYCLES+1). It never wraps: the compare is done before the increment.
- Channels are fully independent. Simultaneous events on several channels each produce their own pulse in the same cycle.
- Button held high through reset release: the channel leaves reset in STABLE_LO, then debounces normally and produces one btnPress after the latency above.
- anyActive is combinational from the state registers. It is 0 in reset.

Decomposition:
- Shared package (joins the existing BasicTypes/Types imports):
  - enum BtnState {STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO};
  - localparam BTN_CENTER=0, BTN_UP=1, BTN_DOWN=2 (channel index constants);
  - typedef logic [NUM_BTN-1:0] BtnVec.
- Sub-module debounce_channel: one synchronizer, FSM and counter per channel, instantiated NUM_BTN times with a generate loop. The top level only wires the vectors and the anyActive OR-reduce.

Test Plan (DEBOUNCE_CYCLES=4, SYNC_STAGES=2):
- Reset: hold rst=0 for 3 cycles with btnRaw=3'b111 -> all outputs 0 during reset. After release, btnPress=3'b111 for exactly one cycle, 5 edges after the first sample. btnLevel then holds at 3'b111.
- Clean press/release on channel 0: 0->1, hold 10 cycles, then 1->0 -> one btnPress[0] pulse and one btnRelease[0] pulse, each 5 edges after its step. btnLevel[0] is high for exactly 10 cycles.
- Bounce reject: drive 1,0,1,1,0 on btnRaw[1] then hold 0 -> no pulse, btnLevel[1]=0. anyActive=1 during WAIT_HI, then back to 0.
- Bounce then settle: drive 1,0 then hold 1 -> exactly one btnPress[1]. It arrives 5 edges after the final 0->1 step.
- Reset mid-debounce: assert rst=0 two edges into WAIT_HI on channel 2, release with btnRaw[2]=1 -> the count restarts from 0 and exactly one btnPress[2] arrives 5 edges after reset release.
- Simultaneous: channel 0 rising and channel 2 falling (from STABLE_HI) on the same edge -> btnPress[0] and btnRelease[2] assert in the same cycle. Channel 1 is unaffected.
